// File: rtl/mv_frame_buf_pkg.sv
// Shared widths, motion-vector field layout, read-state encoding and the
// |x|+|y| helper used by the optional frame-sum logic (MV_FRAME_SUM_EN).
package mv_frame_buf_pkg;

    localparam int MV_W     = 8;
    localparam int ADDR_W   = 6;
    localparam int BLOCKS   = 64;
    localparam int SUM_W    = 11;
    localparam int MV_FLD_W = 4;
    localparam int MV_X_LSB = 4;
    localparam int MV_Y_LSB = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_e;

    // |x|+|y| of a packed vector; -8 maps to 8, so the result needs one extra bit.
    function automatic logic [MV_FLD_W:0] mv_mag(input logic [MV_W-1:0] v);
        logic [MV_FLD_W-1:0] x;
        logic [MV_FLD_W-1:0] y;
        logic [MV_FLD_W-1:0] ax;
        logic [MV_FLD_W-1:0] ay;
        x  = v[MV_X_LSB +: MV_FLD_W];
        y  = v[MV_Y_LSB +: MV_FLD_W];
        ax = x[MV_FLD_W-1] ? (~x + 4'd1) : x;
        ay = y[MV_FLD_W-1] ? (~y + 4'd1) : y;
        return {1'b0, ax} + {1'b0, ay};
    endfunction

endpackage

// File: rtl/mv_frame_buf_bank.sv
// One 64-entry vector bank with its written-bitmap; flags the write that
// completes the frame and clears the bitmap on that same edge.
module mv_bank
    import mv_frame_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [MV_W-1:0]   data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [MV_W-1:0]   rd_data_o,
    output logic              complete_o
);

    logic [MV_W-1:0]   mem_q [BLOCKS];
    logic [BLOCKS-1:0] map_q;
    logic [BLOCKS-1:0] map_d;
    logic [BLOCKS-1:0] hit_s;

    // Bitmap next state and all-written detect for the current write.
    always_comb begin
        hit_s      = {{(BLOCKS-1){1'b0}}, 1'b1} << addr_i;
        complete_o = we_i && (&(map_q | hit_s));
        rd_data_o  = mem_q[rd_addr_i];
        if (!we_i) begin
            map_d = map_q;
        end else if (complete_o) begin
            map_d = {BLOCKS{1'b0}};
        end else begin
            map_d = map_q | hit_s;
        end
    end

    // Vector storage; contents are only meaningful under the bitmap, so no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= data_i;
        end
    end

    // Written-bitmap register.
    always_ff @(posedge clk) begin
        if (rst) begin
            map_q <= {BLOCKS{1'b0}};
        end else begin
            map_q <= map_d;
        end
    end

endmodule

// File: rtl/mv_frame_buf.sv
// Ping-pong motion-vector frame buffer: random-order fill, raster-order drain.
// Optional per-frame |x|+|y| total on out_sum when MV_FRAME_SUM_EN is defined.
module mv_frame_buf
    import mv_frame_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mv_valid,
    input  logic [MV_W-1:0]   mv,
    input  logic [ADDR_W-1:0] mv_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MV_W-1:0]   out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic [SUM_W-1:0]  out_sum,
    output logic              stall,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    rd_state_e         state_q;
    logic [ADDR_W-1:0] rd_cnt_q;
    logic              rd_sel_q;
    logic              wr_sel_q;
    logic [1:0]        full_q;
    logic [1:0]        full_d;
    logic              stall_q;
    logic              overrun_q;
    logic              out_valid_q;
    logic [MV_W-1:0]   out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              out_last_q;

    logic              accept_s;
    logic [1:0]        we_s;
    logic [1:0]        complete_s;
    logic              wr_done_s;
    logic              beat_s;
    logic              last_beat_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [MV_W-1:0]   rd_data_s [2];
    logic [MV_W-1:0]   rd_word_s;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        mv_bank u_bank (
            .clk        (clk),
            .rst        (rst),
            .we_i       (we_s[b]),
            .addr_i     (mv_addr),
            .data_i     (mv),
            .rd_addr_i  (rd_addr_s),
            .rd_data_o  (rd_data_s[b]),
            .complete_o (complete_s[b])
        );
    end

    // Write gating uses the registered full flag, so a bank freed this cycle
    // still refuses this cycle's vector. The read address looks one beat ahead.
    always_comb begin
        accept_s    = mv_valid & ~full_q[wr_sel_q];
        we_s        = {accept_s & wr_sel_q, accept_s & ~wr_sel_q};
        wr_done_s   = complete_s[wr_sel_q];
        beat_s      = out_valid_q & out_ready;
        last_beat_s = beat_s & (rd_cnt_q == LAST_ADDR);
        rd_addr_s   = out_valid_q ? (rd_cnt_q + ADDR_ONE) : ADDR_ZERO;
        rd_word_s   = rd_sel_q ? rd_data_s[1] : rd_data_s[0];
        full_d[0]   = (full_q[0] | (wr_done_s & ~wr_sel_q)) & ~(last_beat_s & ~rd_sel_q);
        full_d[1]   = (full_q[1] | (wr_done_s &  wr_sel_q)) & ~(last_beat_s &  rd_sel_q);
    end

    // Ping-pong control, status flags and the IDLE/DRAIN read FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_cnt_q    <= ADDR_ZERO;
            rd_sel_q    <= 1'b0;
            wr_sel_q    <= 1'b0;
            full_q      <= 2'b00;
            stall_q     <= 1'b0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {MV_W{1'b0}};
            out_addr_q  <= ADDR_ZERO;
            out_last_q  <= 1'b0;
        end else begin
            full_q  <= full_d;
            stall_q <= full_d[0] & full_d[1];
            if (wr_done_s) begin
                wr_sel_q <= ~wr_sel_q;
            end
            if (mv_valid && full_q[wr_sel_q]) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (full_q[rd_sel_q]) begin
                        state_q     <= DRAIN;
                        rd_cnt_q    <= ADDR_ZERO;
                        out_valid_q <= 1'b1;
                        out_data_q  <= rd_word_s;
                        out_addr_q  <= ADDR_ZERO;
                        out_last_q  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (last_beat_s) begin
                        state_q     <= IDLE;
                        rd_sel_q    <= ~rd_sel_q;
                        rd_cnt_q    <= ADDR_ZERO;
                        out_valid_q <= 1'b0;
                        out_data_q  <= {MV_W{1'b0}};
                        out_addr_q  <= ADDR_ZERO;
                        out_last_q  <= 1'b0;
                    end else if (beat_s) begin
                        rd_cnt_q   <= rd_addr_s;
                        out_data_q <= rd_word_s;
                        out_addr_q <= rd_addr_s;
                        out_last_q <= (rd_addr_s == LAST_ADDR);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef MV_FRAME_SUM_EN
    logic [SUM_W-1:0] sum_q [2];
    logic [SUM_W-1:0] out_sum_q;

    // Per-bank totals; a bank's total is zeroed when it is freed, so it is
    // already clear by the time that bank starts filling again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q[0] <= {SUM_W{1'b0}};
            sum_q[1] <= {SUM_W{1'b0}};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (last_beat_s && (rd_sel_q == i[0])) begin
                    sum_q[i] <= {SUM_W{1'b0}};
                end else if (we_s[i]) begin
                    sum_q[i] <= sum_q[i] + SUM_W'(mv_mag(mv));
                end
            end
        end
    end

    // Present the drained bank's total only alongside the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum_q <= {SUM_W{1'b0}};
        end else if (beat_s && (rd_addr_s == LAST_ADDR)) begin
            out_sum_q <= rd_sel_q ? sum_q[1] : sum_q[0];
        end else if (beat_s) begin
            out_sum_q <= {SUM_W{1'b0}};
        end
    end

    assign out_sum = out_sum_q;
`else
    assign out_sum = {SUM_W{1'b0}};
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign stall     = stall_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mv_frame_buf.sv
// Directed scoreboard bench for mv_frame_buf; honours MV_FRAME_SUM_EN for out_sum.
module tb_mv_frame_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        mv_valid;
    logic [7:0]  mv;
    logic [5:0]  mv_addr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [5:0]  out_addr;
    logic        out_last;
    logic [10:0] out_sum;
    logic        stall;
    logic        overrun;

    always #5 clk = ~clk;

    mv_frame_buf dut (
        .clk       (clk),
        .rst       (rst),
        .mv_valid  (mv_valid),
        .mv        (mv),
        .mv_addr   (mv_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .out_sum   (out_sum),
        .stall     (stall),
        .overrun   (overrun)
    );

    typedef struct packed {
        logic [7:0]  d;
        logic [5:0]  a;
        logic        l;
        logic [10:0] s;
    } beat_t;

    beat_t       exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  m_mem [64];
    logic [63:0] m_map;
    int          m_sum;
    int          m_pend;
    int          beats;
    logic        hold_v;
    logic [7:0]  h_d;
    logic [5:0]  h_a;
    logic        h_l;

    function automatic int bmag(input logic [7:0] v);
        int x;
        int y;
        x = int'(signed'(v[7:4]));
        y = int'(signed'(v[3:0]));
        if (x < 0) x = -x;
        if (y < 0) y = -y;
        return x + y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_map  = 64'd0;
        m_sum  = 0;
        m_pend = 0;
        exp_q.delete();
    endtask

    // One clock: check hold/idle/beat before the edge, then step to #1 past it.
    task automatic cycle();
        beat_t e;
        if (hold_v) begin
            chk("hold_data", 32'(out_data), 32'(h_d));
            chk("hold_addr", 32'(out_addr), 32'(h_a));
            chk("hold_last", 32'(out_last), 32'(h_l));
        end
        hold_v = out_valid && !out_ready && !rst;
        h_d = out_data;
        h_a = out_addr;
        h_l = out_last;
        if (out_valid === 1'b0)
            chk("idle_zero", {7'd0, out_data, out_addr, out_last, out_sum}, 32'd0);
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(out_data), 32'(e.d));
                chk("beat_addr", 32'(out_addr), 32'(e.a));
                chk("beat_last", 32'(out_last), 32'(e.l));
                chk("beat_sum", 32'(out_sum), 32'(e.s));
                beats++;
                if (e.l) m_pend--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        beat_t e;
        mv_valid = 1'b1;
        mv       = d;
        mv_addr  = a;
        if (m_pend < 2) begin
            m_mem[a] = d;
            m_map[a] = 1'b1;
            m_sum += bmag(d);
            if (&m_map) begin
                for (int i = 0; i < 64; i++) begin
                    e.d = m_mem[i];
                    e.a = 6'(i);
                    e.l = (i == 63);
`ifdef MV_FRAME_SUM_EN
                    e.s = (i == 63) ? 11'(m_sum) : 11'd0;
`else
                    e.s = 11'd0;
`endif
                    exp_q.push_back(e);
                end
                m_pend++;
                m_map = 64'd0;
                m_sum = 0;
            end
        end
        cycle();
        mv_valid = 1'b0;
    endtask

    task automatic frame_const(input logic [7:0] d);
        for (int a = 0; a < 64; a++) wr(6'(a), d);
    endtask

    task automatic frame_rand();
        for (int a = 0; a < 64; a++) wr(6'(a), 8'($urandom));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int b0;
        rst = 1'b1; mv_valid = 1'b0; mv = 8'd0; mv_addr = 6'd0; out_ready = 1'b0;
        hold_v = 1'b0; beats = 0;
        model_reset();
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_out", {7'd0, out_data, out_addr, out_last, out_sum}, 32'd0);
        rst = 1'b0;
        cycle();

        // In-order frame, mv = addr, and first-beat latency
        out_ready = 1'b1;
        for (int a = 0; a < 64; a++) wr(6'(a), 8'(a));
        chk("lat_edge1", 32'(out_valid), 32'd0);
        cycle();
        chk("lat_edge2", 32'(out_valid), 32'd1);
        chk("lat_addr0", 32'(out_addr), 32'd0);
        drain(200);

        // Reverse order with a duplicate to addr 5
        for (int a = 63; a >= 5; a--) wr(6'(a), (a == 5) ? 8'h11 : 8'($urandom));
        wr(6'd5, 8'h22);
        for (int a = 4; a >= 1; a--) wr(6'(a), 8'($urandom));
        repeat (3) cycle();
        chk("no_early_frame", 32'(out_valid), 32'd0);
        wr(6'd0, 8'($urandom));
        drain(200);

        // Backpressure toggling mid-drain
        out_ready = 1'b0;
        frame_rand();
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            out_ready = (n % 2 == 0);
            cycle();
            n++;
        end
        chk("toggle_left", 32'(exp_q.size()), 32'd0);

        // Sum boundaries
        out_ready = 1'b1;
        frame_const(8'h88);
        drain(200);
        frame_const(8'h1F);
        drain(200);

        // Three frames against a stalled consumer
        out_ready = 1'b0;
        frame_rand();
        chk("stall_one", 32'(stall), 32'd0);
        frame_rand();
        chk("stall_two", 32'(stall), 32'd1);
        chk("overrun_pre", 32'(overrun), 32'd0);
        frame_rand();
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("stall_held", 32'(stall), 32'd1);
        drain(400);
        repeat (3) cycle();
        chk("third_dropped", 32'(out_valid), 32'd0);
        chk("stall_clear", 32'(stall), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Reset mid-fill discards the partial frame
        out_ready = 1'b1;
        for (int a = 0; a < 30; a++) wr(6'(a), 8'($urandom));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        model_reset();
        chk("rst1_out", {7'd0, out_data, out_addr, out_last, out_sum}, 32'd0);
        chk("rst1_flags", {29'd0, out_valid, stall, overrun}, 32'd0);
        for (int a = 30; a < 64; a++) wr(6'(a), 8'($urandom));
        repeat (3) cycle();
        chk("partial_gone", 32'(out_valid), 32'd0);
        for (int a = 0; a < 30; a++) wr(6'(a), 8'($urandom));

        // Reset at drain beat 10
        b0 = beats;
        n = 0;
        while (beats < b0 + 10 && n < 300) begin
            cycle();
            n++;
        end
        chk("pre_rst_addr", 32'(out_addr), 32'd10);
        out_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        model_reset();
        chk("rst2_out", {7'd0, out_data, out_addr, out_last, out_sum}, 32'd0);
        chk("rst2_flags", {29'd0, out_valid, stall, overrun}, 32'd0);
        out_ready = 1'b1;
        frame_rand();
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
